// File: rtl/mult_unit_if.sv
// rtl/mult_unit_if.sv - request/write-back bundle between the issue stage and mult_unit
interface mult_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic             sel_hi;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [4:0]       dest_reg;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             wb_en;
    logic [WIDTH-1:0] wb_data;
    logic [4:0]       wb_reg;

    modport master (
        output start, is_signed, sel_hi, operand_a, operand_b, dest_reg,
        input  busy, done, result_hi, result_lo, wb_en, wb_data, wb_reg
    );

    modport slave (
        input  start, is_signed, sel_hi, operand_a, operand_b, dest_reg,
        output busy, done, result_hi, result_lo, wb_en, wb_data, wb_reg
    );
endinterface

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - iterative radix-2 shift-add multiplier with register write-back
module mult_unit #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst_n,
    mult_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 neg_q;
    logic                 sel_hi_q;
    logic [4:0]           wb_reg_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     res_hi_q;
    logic [WIDTH-1:0]     res_lo_q;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       upper_sum;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_final;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start only matters in IDLE, CALC runs a fixed WIDTH steps
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == LAST_STEP) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes; the negation of the most negative value is its own
    // bit pattern, which read as unsigned is exactly the required magnitude
    always_comb begin
        a_mag = (bus.is_signed && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
        b_mag = (bus.is_signed && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
    end

    // One shift-add step; the carry out of the upper-half add shifts into the top bit
    always_comb begin
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (mplier_q[0]) begin
            upper_sum = upper_sum + {1'b0, mcand_q};
        end
        acc_step   = {upper_sum, acc_q[WIDTH-1:1]};
        prod_final = neg_q ? -acc_step : acc_step;
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q    <= 1'b0;
            sel_hi_q <= 1'b0;
            wb_reg_q <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        neg_q    <= bus.is_signed & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                        sel_hi_q <= bus.sel_hi;
                        wb_reg_q <= bus.dest_reg;
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                CALC: begin
                    acc_q    <= acc_step;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        res_hi_q <= prod_final[2*WIDTH-1:WIDTH];
                        res_lo_q <= prod_final[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.wb_en     = (state_q == DONE);
    assign bus.result_hi = res_hi_q;
    assign bus.result_lo = res_lo_q;
    assign bus.wb_data   = sel_hi_q ? res_hi_q : res_lo_q;
    assign bus.wb_reg    = wb_reg_q;
endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  1 = signed (mult), 0 = unsigned (multu); captured with start.
REQ-006 SHALL have port sel_hi  input  1  selects result_hi (1) or result_lo (0) for write-back; captured with start.
REQ-007 SHALL have port operand_a  input  32  multiplicand, driven from register-file read_data1.
REQ-008 SHALL have port operand_b  input  32  multiplier, driven from register-file read_data2.
REQ-009 SHALL have port dest_reg  input  5  write-back register index; captured with start.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse, high while state is DONE.
REQ-012 SHALL have port result_hi  output  32  upper product word, registered.
REQ-013 SHALL have port result_lo  output  32  lower product word, registered.
REQ-014 SHALL have port wb_en  output  1  register-file write strobe (to regWrite); equals done.
REQ-015 SHALL have port wb_data  output  32  write data (to write_data): sel_hi ? result_hi : result_lo, using the captured sel_hi.
REQ-016 SHALL have port wb_reg  output  5  write register (to write_reg): captured dest_reg.

Function
REQ-017 SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-018 In IDLE, SHALL leave IDLE only when start=1 is sampled; it SHALL then capture is_signed, sel_hi, and dest_reg, capture |operand_a| and |operand_b| (magnitude if is_signed, raw value otherwise), and capture the sign neg = is_signed & (a[31]^b[31]), then clear the 64-bit accumulator and the 5-bit counter and enter CALC.
REQ-019 In CALC, each edge SHALL perform one radix-2 shift-add step: if multiplier LSB = 1, add the multiplicand to the accumulator upper half (33-bit carry kept), then shift the accumulator/multiplier right by 1; counter increments.
REQ-020 SHALL perform exactly 32 CALC steps, irrespective of operand values (zero operands included); the edge performing step 32 (counter = 31) SHALL enter DONE.
REQ-021 On that same edge, SHALL load result_hi/result_lo with the final 64-bit product, two's-complemented across all 64 bits when neg=1.
REQ-022 Latency: with start sampled at edge E0, steps run on edges E1..E32, done/wb_en are high for the single cycle between E32 and E33, and E33 returns to IDLE.
REQ-023 Magnitude of 0x80000000 SHALL be treated as unsigned 2^31 (33-bit-safe); no overflow is possible in a 64-bit product.
REQ-024 start while busy=1 (CALC or DONE) SHALL be ignored, with no effect on captured operands or results.
REQ-025 If start is held high, a new operation SHALL begin at the first IDLE edge (E33 samples IDLE -> earliest re-sample E34); the next start after DONE requires an IDLE cycle.
REQ-026 result_hi/result_lo SHALL hold their values until the next load (REQ-021).
REQ-027 wb_en SHALL never be asserted outside DONE; exactly one write SHALL occur per accepted start.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, and force busy, done, and wb_en to 0, result_hi/result_lo/wb_data to 0, and wb_reg/counter/accumulator to 0.
REQ-029 Reset mid-operation SHALL abort the operation with no done or wb_en pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-030 Unsigned 0xFFFFFFFF x 0xFFFFFFFF, sel_hi=0, dest_reg=8 -> done exactly 32 cycles after the start edge; result_hi=0xFFFFFFFE, result_lo=0x00000001, wb_data=0x00000001, wb_reg=8, with a single wb_en pulse.
REQ-031 Signed -3 (0xFFFFFFFD) x 7, sel_hi=1 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB, wb_data=0xFFFFFFFF.
REQ-032 Signed 0x80000000 x 0x80000000 -> result_hi=0x40000000, result_lo=0x00000000; signed 0x80000000 x 1 -> result_hi=0xFFFFFFFF, result_lo=0x80000000.
REQ-033 Start 5 x 6, then pulse start with 9 x 9 on cycle 10 -> second request ignored; results 0/30, one wb_en only.
REQ-034 Assert rst_n=0 on cycle 10 of CALC -> busy, done, and wb_en are 0 immediately, results are 0, and no write occurs; a subsequent start 2 x 3 yields result_lo=6.
REQ-035 Hold start=1 continuously with 4 x 4 -> done pulses every 34 cycles, with one IDLE cycle between operations, each producing result_lo=16.
